// File: rtl/coin_credit_ctrl_if.sv
// Bundle of vending-machine front-end signals: raw buttons and price in, credit/change/status out.
// The master side drives buttons and price; the controller is the slave.
interface coin_credit_ctrl_if;
    logic [3:0] COIN_N;
    logic       CANCEL_N;
    logic       VEND_SW;
    logic [3:0] PRICE;
    logic [4:0] CREDIT;
    logic [4:0] CHANGE;
    logic       DISPENSE;
    logic       REFUND;
    logic       REJECT;
    logic       DENY;
    logic       BUSY;

    modport master (
        output COIN_N, CANCEL_N, VEND_SW, PRICE,
        input  CREDIT, CHANGE, DISPENSE, REFUND, REJECT, DENY, BUSY
    );

    modport slave (
        input  COIN_N, CANCEL_N, VEND_SW, PRICE,
        output CREDIT, CHANGE, DISPENSE, REFUND, REJECT, DENY, BUSY
    );
endinterface

// File: rtl/coin_credit_ctrl.sv
// Coin/cancel/vend front end: synchronizes and debounces buttons, accumulates credit
// and sequences the timed dispense/refund indication.
//
// state | meaning
// IDLE  | accepting coins, cancel and vend requests
// VEND  | DISPENSE held for HOLD_CYCLES, then credit cleared
// RFND  | REFUND held for HOLD_CYCLES, then credit cleared
module coin_credit_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int HOLD_W          = 26
) (
    input logic               CLOCK_50,
    input logic               RST,
    coin_credit_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, VEND, RFND} state_t;

    localparam int NCH = 6;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Channel order in pressed polarity: [3:0] coins, [4] cancel, [5] vend switch.
    logic [NCH-1:0]  raw;
    logic [NCH-1:0]  sync1;
    logic [NCH-1:0]  sync2;
    logic [NCH-1:0]  stable;
    logic [NCH-1:0]  arm;
    logic [NCH-1:0]  evt;
    logic [DB_W-1:0] cnt [NCH];

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [4:0]        credit;
    logic [4:0]        change;
    logic              dispense;
    logic              refund;
    logic              reject;
    logic              deny;
    logic              busy;

    logic [3:0] coin_evt;
    logic       cancel_evt;
    logic       vend_evt;
    logic       coin_one;
    logic [4:0] coin_val;
    logic [5:0] coin_sum;

    assign raw = {bus.VEND_SW, ~bus.CANCEL_N, ~bus.COIN_N};

    always_ff @(posedge CLOCK_50) begin
        sync1 <= raw;
        sync2 <= sync1;
    end

    // A channel stays disarmed after reset until it has been seen released for a full
    // debounce window, so a button held through reset cannot raise an event.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            stable <= '0;
            arm    <= '0;
            evt    <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                evt[i] <= 1'b0;
                if (!arm[i]) begin
                    if (sync2[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == DB_LAST) begin
                        arm[i] <= 1'b1;
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else if (sync2[i] != stable[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        stable[i] <= sync2[i];
                        evt[i]    <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign coin_evt   = evt[3:0];
    assign cancel_evt = evt[4];
    assign vend_evt   = evt[5];
    assign coin_one   = $onehot(coin_evt);

    always_comb begin
        coin_val = 5'd0;
        if (coin_evt[0]) begin
            coin_val = 5'd1;
        end else if (coin_evt[1]) begin
            coin_val = 5'd2;
        end else if (coin_evt[2]) begin
            coin_val = 5'd5;
        end else if (coin_evt[3]) begin
            coin_val = 5'd10;
        end
    end

    // One bit wider so an overflowing insert can be refused instead of wrapping.
    assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state    <= IDLE;
            hold_cnt <= '0;
            credit   <= '0;
            change   <= '0;
            dispense <= 1'b0;
            refund   <= 1'b0;
            reject   <= 1'b0;
            deny     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            reject <= 1'b0;
            deny   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cancel_evt && credit != 5'd0) begin
                        change   <= credit;
                        refund   <= 1'b1;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_LAST;
                        state    <= RFND;
                        reject   <= |coin_evt;
                    end else if (vend_evt) begin
                        reject <= |coin_evt;
                        if (bus.PRICE != 4'd0 && credit >= {1'b0, bus.PRICE}) begin
                            change   <= credit - {1'b0, bus.PRICE};
                            dispense <= 1'b1;
                            busy     <= 1'b1;
                            hold_cnt <= HOLD_LAST;
                            state    <= VEND;
                        end else begin
                            deny <= 1'b1;
                        end
                    end else if (|coin_evt) begin
                        if (coin_one && coin_sum <= 6'd31) begin
                            credit <= coin_sum[4:0];
                            change <= 5'd0;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                VEND, RFND: begin
                    reject <= |coin_evt;
                    if (hold_cnt == '0) begin
                        credit   <= 5'd0;
                        dispense <= 1'b0;
                        refund   <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CREDIT   = credit;
    assign bus.CHANGE   = change;
    assign bus.DISPENSE = dispense;
    assign bus.REFUND   = refund;
    assign bus.REJECT   = reject;
    assign bus.DENY     = deny;
    assign bus.BUSY     = busy;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Directed bench for coin_credit_ctrl with short debounce and hold times:
// a vector table of button presses plus hand sequences for latency, bounce and reset.
module tb_coin_credit_ctrl;

    logic CLOCK_50 = 1'b0;
    logic RST;

    always #5 CLOCK_50 = ~CLOCK_50;

    coin_credit_ctrl_if bus ();

    coin_credit_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DB_W           (3),
        .HOLD_CYCLES    (8),
        .HOLD_W         (4)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RST     (RST),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] coin;
        logic       cancel;
        logic       vend;
        logic [3:0] price;
        logic [4:0] credit;
        logic [4:0] change;
        int         rej;
        int         deny;
        int         disp;
        int         refund;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    int total = 0;
    int bad   = 0;
    int n_rej, n_deny, n_disp, n_ref, n_busy;

    task automatic clr_counts();
        n_rej = 0; n_deny = 0; n_disp = 0; n_ref = 0; n_busy = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            n_rej  += int'(bus.REJECT);
            n_deny += int'(bus.DENY);
            n_disp += int'(bus.DISPENSE);
            n_ref  += int'(bus.REFUND);
            n_busy += int'(bus.BUSY);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic release_all();
        bus.COIN_N   = 4'hF;
        bus.CANCEL_N = 1'b1;
        bus.VEND_SW  = 1'b0;
    endtask

    task automatic press(input logic [3:0] coin, input logic cancel, input logic vend,
                         input logic [3:0] price);
        bus.PRICE    = price;
        bus.COIN_N   = ~coin;
        bus.CANCEL_N = ~cancel;
        bus.VEND_SW  = vend;
        tick(10);
        release_all();
        tick(14);
    endtask

    task automatic wait_dispense(input string name);
        int guard;
        guard = 0;
        while (!bus.DISPENSE && guard < 30) begin
            tick(1);
            guard++;
        end
        if (!bus.DISPENSE) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'd0,  5'd15, 5'd0,  0, 0, 0, 0};
        tbl[1]  = '{4'b0010, 1'b0, 1'b0, 4'd0,  5'd17, 5'd0,  0, 0, 0, 0};
        tbl[2]  = '{4'b0000, 1'b0, 1'b1, 4'd10, 5'd0,  5'd7,  0, 0, 8, 0};
        tbl[3]  = '{4'b0001, 1'b0, 1'b0, 4'd10, 5'd1,  5'd0,  0, 0, 0, 0};
        tbl[4]  = '{4'b0010, 1'b0, 1'b0, 4'd10, 5'd3,  5'd0,  0, 0, 0, 0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b1, 4'd5,  5'd3,  5'd0,  0, 1, 0, 0};
        tbl[6]  = '{4'b0011, 1'b0, 1'b0, 4'd5,  5'd3,  5'd0,  1, 0, 0, 0};
        tbl[7]  = '{4'b1000, 1'b0, 1'b0, 4'd5,  5'd13, 5'd0,  0, 0, 0, 0};
        tbl[8]  = '{4'b1000, 1'b0, 1'b0, 4'd5,  5'd23, 5'd0,  0, 0, 0, 0};
        tbl[9]  = '{4'b0010, 1'b0, 1'b0, 4'd5,  5'd25, 5'd0,  0, 0, 0, 0};
        tbl[10] = '{4'b1000, 1'b0, 1'b0, 4'd5,  5'd25, 5'd0,  1, 0, 0, 0};
        tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'd5,  5'd0,  5'd25, 0, 0, 0, 8};
        tbl[12] = '{4'b1000, 1'b0, 1'b0, 4'd5,  5'd10, 5'd0,  0, 0, 0, 0};
        tbl[13] = '{4'b1000, 1'b0, 1'b0, 4'd5,  5'd20, 5'd0,  0, 0, 0, 0};
        tbl[14] = '{4'b0001, 1'b0, 1'b0, 4'd5,  5'd21, 5'd0,  0, 0, 0, 0};
        tbl[15] = '{4'b1000, 1'b0, 1'b0, 4'd5,  5'd31, 5'd0,  0, 0, 0, 0};
        tbl[16] = '{4'b0001, 1'b0, 1'b0, 4'd5,  5'd31, 5'd0,  1, 0, 0, 0};
        tbl[17] = '{4'b0000, 1'b1, 1'b0, 4'd5,  5'd0,  5'd31, 0, 0, 0, 8};
        tbl[18] = '{4'b0000, 1'b1, 1'b0, 4'd5,  5'd0,  5'd31, 0, 0, 0, 0};
        tbl[19] = '{4'b1000, 1'b0, 1'b0, 4'd5,  5'd10, 5'd0,  0, 0, 0, 0};
        tbl[20] = '{4'b0010, 1'b0, 1'b0, 4'd5,  5'd12, 5'd0,  0, 0, 0, 0};
        tbl[21] = '{4'b0000, 1'b1, 1'b1, 4'd5,  5'd0,  5'd12, 0, 0, 0, 8};
        tbl[22] = '{4'b0100, 1'b0, 1'b0, 4'd5,  5'd5,  5'd0,  0, 0, 0, 0};
        tbl[23] = '{4'b0000, 1'b0, 1'b1, 4'd0,  5'd5,  5'd0,  0, 1, 0, 0};
        tbl[24] = '{4'b0000, 1'b0, 1'b1, 4'd5,  5'd0,  5'd0,  0, 0, 8, 0};

        release_all();
        bus.PRICE = 4'd0;
        RST = 1'b1;
        clr_counts();
        tick(3);
        check("rst_credit",   int'(bus.CREDIT),   0);
        check("rst_change",   int'(bus.CHANGE),   0);
        check("rst_dispense", int'(bus.DISPENSE), 0);
        check("rst_refund",   int'(bus.REFUND),   0);
        check("rst_reject",   int'(bus.REJECT),   0);
        check("rst_deny",     int'(bus.DENY),     0);
        check("rst_busy",     int'(bus.BUSY),     0);
        RST = 1'b0;
        tick(8);

        // First coin: update must land exactly 6 edges after first sample.
        bus.COIN_N = 4'b0111;
        tick(6);
        check("lat_before", int'(bus.CREDIT), 0);
        tick(1);
        check("lat_at",     int'(bus.CREDIT), 10);
        tick(3);
        release_all();
        tick(14);

        for (int i = 0; i < NVEC; i++) begin
            clr_counts();
            press(tbl[i].coin, tbl[i].cancel, tbl[i].vend, tbl[i].price);
            check($sformatf("v%0d_credit", i), int'(bus.CREDIT), int'(tbl[i].credit));
            check($sformatf("v%0d_change", i), int'(bus.CHANGE), int'(tbl[i].change));
            check($sformatf("v%0d_reject", i), n_rej,  tbl[i].rej);
            check($sformatf("v%0d_deny",   i), n_deny, tbl[i].deny);
            check($sformatf("v%0d_disp",   i), n_disp, tbl[i].disp);
            check($sformatf("v%0d_refund", i), n_ref,  tbl[i].refund);
            check($sformatf("v%0d_busy",   i), n_busy, tbl[i].disp + tbl[i].refund);
        end

        // Bouncing coin 1: no event while toggling, one event once held.
        clr_counts();
        for (int i = 0; i < 5; i++) begin
            bus.COIN_N = 4'b1110;
            tick(2);
            bus.COIN_N = 4'b1111;
            tick(2);
        end
        check("bounce_mid", int'(bus.CREDIT), 0);
        bus.COIN_N = 4'b1110;
        tick(10);
        release_all();
        tick(14);
        check("bounce_credit", int'(bus.CREDIT), 1);
        check("bounce_reject", n_rej, 0);

        bus.COIN_N = 4'b1110;
        tick(3);
        release_all();
        tick(14);
        check("glitch_credit", int'(bus.CREDIT), 1);

        // Coin pressed while dispensing is refused and credit still clears.
        clr_counts();
        bus.PRICE   = 4'd1;
        bus.VEND_SW = 1'b1;
        wait_dispense("midvend");
        bus.COIN_N = 4'b0111;
        tick(10);
        release_all();
        tick(14);
        check("midvend_change", int'(bus.CHANGE), 0);
        check("midvend_disp",   n_disp, 8);
        check("midvend_reject", n_rej,  1);
        check("midvend_credit", int'(bus.CREDIT), 0);

        // Reset in the 4th dispense cycle aborts everything.
        press(4'b1000, 1'b0, 1'b0, 4'd3);
        check("pre_rst_credit", int'(bus.CREDIT), 10);
        bus.VEND_SW = 1'b1;
        wait_dispense("rstvend");
        tick(3);
        check("rstvend_disp_c4", int'(bus.DISPENSE), 1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check("rstvend_credit",   int'(bus.CREDIT),   0);
        check("rstvend_change",   int'(bus.CHANGE),   0);
        check("rstvend_dispense", int'(bus.DISPENSE), 0);
        check("rstvend_busy",     int'(bus.BUSY),     0);
        release_all();
        tick(14);
        check("rstvend_after", int'(bus.CREDIT), 0);

        // Coin held through reset must be released and pressed again.
        clr_counts();
        bus.COIN_N = 4'b1110;
        tick(2);
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        tick(20);
        check("held_credit", int'(bus.CREDIT), 0);
        release_all();
        tick(10);
        press(4'b0001, 1'b0, 1'b0, 4'd3);
        check("held_repress", int'(bus.CREDIT), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
